// File: rtl/rxuart_fifo.sv
// Receive-side first-word-fall-through FIFO for UART bytes. Each entry carries its
// parity/framing flags; reports fill, half-full, sticky overflow and a registered break.
module rxuart_fifo #(
  parameter int LGFLEN = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr,
  input  logic [7:0]        i_data,
  input  logic              i_parity_err,
  input  logic              i_frame_err,
  input  logic              i_break,
  input  logic              i_rd,
  input  logic              i_clr_ovfl,
  output logic              o_empty_n,
  output logic [7:0]        o_data,
  output logic              o_perr,
  output logic              o_ferr,
  output logic [LGFLEN:0]   o_fill,
  output logic              o_half_full,
  output logic              o_overflow,
  output logic              o_break
);
  localparam int DEPTH = 1 << LGFLEN;
  localparam logic [LGFLEN:0] FULL_LVL = (LGFLEN+1)'(DEPTH);
  localparam logic [LGFLEN:0] HALF_LVL = (LGFLEN+1)'(DEPTH / 2);

  logic [9:0]        mem [DEPTH];
  logic [LGFLEN-1:0] rd_ptr;
  logic [LGFLEN-1:0] wr_ptr;
  logic [LGFLEN:0]   fill;
  logic              full;
  logic              nonempty;
  logic              do_wr;
  logic              do_rd;
  logic              drop;
  logic [9:0]        head;

  assign full     = (fill == FULL_LVL);
  assign nonempty = (fill != '0);
  assign do_rd    = i_rd && nonempty;
  // At full, a same-cycle pop frees the slot, so the write still goes in.
  assign do_wr    = i_wr && !i_break && (!full || i_rd);
  assign drop     = i_wr && !i_break && full && !i_rd;

  always_ff @(posedge i_clk) begin
    if (do_wr) mem[wr_ptr] <= {i_frame_err, i_parity_err, i_data};
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fill       <= '0;
      o_overflow <= 1'b0;
      o_break    <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + LGFLEN'(1);
      if (do_rd) rd_ptr <= rd_ptr + LGFLEN'(1);
      case ({do_wr, do_rd})
        2'b10:   fill <= fill + (LGFLEN+1)'(1);
        2'b01:   fill <= fill - (LGFLEN+1)'(1);
        default: fill <= fill;
      endcase
      if (drop)            o_overflow <= 1'b1;
      else if (i_clr_ovfl) o_overflow <= 1'b0;
      o_break <= i_break;
    end
  end

  // Head is masked by fill so reset clears the outputs without touching storage.
  assign head        = mem[rd_ptr];
  assign o_empty_n   = nonempty;
  assign o_data      = nonempty ? head[7:0] : 8'h00;
  assign o_perr      = nonempty ? head[8]   : 1'b0;
  assign o_ferr      = nonempty ? head[9]   : 1'b0;
  assign o_fill      = fill;
  assign o_half_full = (fill >= HALF_LVL);

endmodule
